// File: rtl/pll_seq_pkg.sv
// Shared definitions for the multi-device PLL init sequencer: the
// sequencer state encoding, lock-supervision defaults and a width helper.
package pll_seq_pkg;

    localparam int DEF_LOCK_TIMEOUT = 65535;
    localparam int DEF_MAX_RETRY    = 2;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        LOCK_WAIT,
        NEXT_DEV,
        HOST_WR,
        FINISH
    } seq_state_t;

    // Index width that never collapses to zero bits for a single device.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_lane_handshake.sv
// SPI lane handshake shared by the table-driven init path and the host
// single-word path. It watches the sequencer state, reports when the current
// handshake phase (ISSUE / WAIT_BUSY / WAIT_DONE) is satisfied, and produces
// the registered one-hot start pulse together with the word to shift.
module spi_lane_handshake
    import pll_seq_pkg::*;
#(
    parameter int NUM_DEV = 2,
    parameter int WORD_W  = 24,
    parameter int DEV_W   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  seq_state_t           state,
    input  logic [DEV_W-1:0]     lane,
    input  logic [WORD_W-1:0]    word,
    input  logic [NUM_DEV-1:0]   spi_ready,
    output logic                 advance,
    output logic [NUM_DEV-1:0]   spi_start,
    output logic [WORD_W-1:0]    spi_data_tx
);

    logic lane_ready;
    logic fire;

    // Pick the idle flag of the addressed lane
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        lane_ready = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (lane == DEV_W'(i)) begin
                lane_ready = spi_ready[i];
            end
        end
    end

    // Report when the current handshake phase may be left
    always_comb begin
        advance = 1'b0;
        fire    = 1'b0;
        case (state)
            ISSUE: begin
                advance = lane_ready;
                fire    = lane_ready;
            end
            WAIT_BUSY: advance = !lane_ready;
            WAIT_DONE: advance = lane_ready;
            default:   advance = 1'b0;
        endcase
    end

    // Register the single-cycle one-hot start pulse and the outgoing word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_start   <= '0;
            spi_data_tx <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            spi_start <= '0;
            if (fire) begin
                for (int i = 0; i < NUM_DEV; i++) begin
                    spi_start[i] <= (lane == DEV_W'(i));
                end
                spi_data_tx <= word;
            end
        end
    end

endmodule

// File: rtl/multi_pll_init_seq.sv
// Multi-device PLL init sequencer. On start it walks each device's register
// table out of a synchronous ROM and pushes every word over that device's SPI
// lane; between runs a host may push single words. Define LOCK_CHECK_EN to add
// per-device lock supervision (2-flop synchroniser, timeout, retries, error
// reporting); without it the sequencer moves straight to the next device.
module multi_pll_init_seq
    import pll_seq_pkg::*;
#(
    parameter int NUM_DEV      = 2,
    parameter int WORD_W       = 24,
    parameter int ADDR_W       = 8,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    localparam int DEV_W       = clog2_min1(NUM_DEV)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_DEV*ADDR_W-1:0]   tbl_base,
    input  logic [NUM_DEV*ADDR_W-1:0]   tbl_len,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [WORD_W-1:0]           rom_data,
    input  logic [NUM_DEV-1:0]          spi_ready,
    output logic [NUM_DEV-1:0]          spi_start,
    output logic [WORD_W-1:0]           spi_data_tx,
    output logic [7:0]                  spi_data_depth,
    input  logic                        wr_req,
    input  logic [DEV_W-1:0]            wr_dev,
    input  logic [WORD_W-1:0]           wr_data,
    output logic                        wr_ack,
    input  logic [NUM_DEV-1:0]          pll_lock,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [DEV_W-1:0]            err_dev
);

    // dev must be able to hold NUM_DEV itself to signal "all devices done"
    localparam int DEV_CW = $clog2(NUM_DEV + 1);

    seq_state_t          state;
    logic [DEV_CW-1:0]   dev;
    logic [ADDR_W-1:0]   idx;
    logic [1:0]          fetch_ph;
    logic [WORD_W-1:0]   rom_word;
    logic                host_mode;
    logic [DEV_W-1:0]    host_lane;
    logic [WORD_W-1:0]   host_word;

    logic                hs_advance;
    logic [DEV_W-1:0]    hs_lane;
    logic [WORD_W-1:0]   hs_word;
    logic [ADDR_W-1:0]   cur_base;
    logic [ADDR_W-1:0]   cur_len;
    logic [ADDR_W:0]     idx_next;
    logic                last_word;
    logic                wr_lane_ok;

    assign spi_data_depth = 8'(WORD_W);

    // Slice the current device's table window and check the host lane index
    always_comb begin
        cur_base   = '0;
        cur_len    = '0;
        wr_lane_ok = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (dev == DEV_CW'(i)) begin
                cur_base = tbl_base[i*ADDR_W +: ADDR_W];
                cur_len  = tbl_len[i*ADDR_W +: ADDR_W];
            end
            if (wr_dev == DEV_W'(i)) begin
                wr_lane_ok = 1'b1;
            end
        end
        idx_next  = {1'b0, idx} + 1'b1;
        last_word = (idx_next >= {1'b0, cur_len});
    end

    assign hs_lane = host_mode ? host_lane : DEV_W'(dev);
    assign hs_word = host_mode ? host_word : rom_word;

    spi_lane_handshake #(
        .NUM_DEV (NUM_DEV),
        .WORD_W  (WORD_W),
        .DEV_W   (DEV_W)
    ) u_handshake (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .lane        (hs_lane),
        .word        (hs_word),
        .spi_ready   (spi_ready),
        .advance     (hs_advance),
        .spi_start   (spi_start),
        .spi_data_tx (spi_data_tx)
    );

`ifdef LOCK_CHECK_EN
    localparam int TMO_W = clog2_min1(LOCK_TIMEOUT + 1);
    localparam int RTY_W = clog2_min1(MAX_RETRY + 1);

    logic [NUM_DEV-1:0]  lock_meta;
    logic [NUM_DEV-1:0]  lock_sync;
    logic [TMO_W-1:0]    lock_cnt;
    logic [RTY_W-1:0]    retry;
    logic                err_q;
    logic [DEV_W-1:0]    err_dev_q;
    logic                cur_lock;

    // Bring the asynchronous lock detects into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= '0;
            lock_sync <= '0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
        end
    end

    // Select the synchronised lock of the device being supervised
    always_comb begin
        cur_lock = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (dev == DEV_CW'(i)) begin
                cur_lock = lock_sync[i];
            end
        end
    end

    assign err     = err_q;
    assign err_dev = err_dev_q;
`else
    logic unused_lock;
    assign unused_lock = ^{pll_lock, (LOCK_TIMEOUT != 0), (MAX_RETRY != 0)};
    assign err         = 1'b0;
    assign err_dev     = '0;
`endif

    // Sequencer: table walk, host single-word writes and lock supervision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dev       <= '0;
            idx       <= '0;
            fetch_ph  <= '0;
            rom_word  <= '0;
            rom_addr  <= '0;
            host_mode <= 1'b0;
            host_lane <= '0;
            host_word <= '0;
            wr_ack    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef LOCK_CHECK_EN
            lock_cnt  <= '0;
            retry     <= '0;
            err_q     <= 1'b0;
            err_dev_q <= '0;
`endif
        end else begin
            wr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // start wins over a simultaneous host request
                    if (start) begin
                        done      <= 1'b0;
                        dev       <= '0;
                        idx       <= '0;
                        host_mode <= 1'b0;
                        busy      <= 1'b1;
                        state     <= NEXT_DEV;
`ifdef LOCK_CHECK_EN
                        err_q     <= 1'b0;
                        retry     <= '0;
`endif
                    end else if (wr_req && wr_lane_ok) begin
                        host_mode <= 1'b1;
                        host_lane <= wr_dev;
                        host_word <= wr_data;
                        busy      <= 1'b1;
                        state     <= HOST_WR;
                    end
                end

                HOST_WR: state <= ISSUE;

                NEXT_DEV: begin
                    if (dev == DEV_CW'(NUM_DEV)) begin
                        state <= FINISH;
                    end else if (cur_len == '0) begin
                        dev <= dev + 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end

                // Present the address, let the ROM respond, then capture
                FETCH: begin
                    case (fetch_ph)
                        2'd0: begin
                            rom_addr <= cur_base + idx;
                            fetch_ph <= 2'd1;
                        end
                        2'd1: fetch_ph <= 2'd2;
                        default: begin
                            rom_word <= rom_data;
                            fetch_ph <= 2'd0;
                            state    <= ISSUE;
                        end
                    endcase
                end

                ISSUE:     if (hs_advance) state <= WAIT_BUSY;
                WAIT_BUSY: if (hs_advance) state <= WAIT_DONE;

                WAIT_DONE: begin
                    if (hs_advance) begin
                        if (host_mode) begin
                            host_mode <= 1'b0;
                            wr_ack    <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else if (!last_word) begin
                            idx   <= idx_next[ADDR_W-1:0];
                            state <= FETCH;
                        end else begin
                            idx <= '0;
`ifdef LOCK_CHECK_EN
                            lock_cnt <= '0;
                            state    <= LOCK_WAIT;
`else
                            dev      <= dev + 1'b1;
                            state    <= NEXT_DEV;
`endif
                        end
                    end
                end

`ifdef LOCK_CHECK_EN
                LOCK_WAIT: begin
                    if (cur_lock) begin
                        retry <= '0;
                        dev   <= dev + 1'b1;
                        state <= NEXT_DEV;
                    end else if (lock_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
                        if (retry < RTY_W'(MAX_RETRY)) begin
                            retry <= retry + 1'b1;
                            idx   <= '0;
                            state <= FETCH;
                        end else begin
                            err_q     <= 1'b1;
                            err_dev_q <= DEV_W'(dev);
                            state     <= FINISH;
                        end
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
`endif

                FINISH: begin
`ifdef LOCK_CHECK_EN
                    done <= !err_q;
`else
                    done <= 1'b1;
`endif
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
